int_jump_ctrl: RTL and testbench
================================

INT_JUMP_CTRL -- requirements
Module: int_jump_ctrl

Interface
REQ-001 SHALL have parameter AW, default 16: address width.
REQ-002 SHALL have parameter NIRQ, default 4: number of interrupt sources.
REQ-003 SHALL have parameter DEPTH, default 4: nesting depth of the return stack.
REQ-004 SHALL have parameter VEC_BASE, default 16'hF000: vector address of IRQ 0.
REQ-005 SHALL have parameter VEC_STRIDE, default 16'h0010: spacing between vectors.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  reset, asynchronous, active-low.
REQ-008 jmp_address_pm  input  AW  jump target from program memory.
REQ-009 current_address  input  AW  PC of the instruction being decoded.
REQ-010 op_dec  input  6  decoded opcode.
REQ-011 flag_ex  input  2  execute flags; [0]=overflow, [1]=zero.
REQ-012 irq  input  NIRQ  level interrupt requests.
REQ-013 irq_en  input  1  global interrupt enable.
REQ-014 jmp_loc  output  AW  PC redirect target.
REQ-015 pc_mux_sel  output  1  select jmp_loc as next PC.
REQ-016 irq_ack  output  NIRQ  one-hot acknowledge pulse.
REQ-017 ret_flags  output  2  flags restored by RET.
REQ-018 ret_flags_vld  output  1  ret_flags valid.
REQ-019 depth  output  clog2(DEPTH+1)  stack occupancy.
REQ-020 stack_udf  output  1  sticky RET-on-empty error.

Function
REQ-021 Opcodes SHALL be: JV 011100, JNV 011101, JZ 011110, JNZ 011111, JMP 011000, RET 010000.
REQ-022 In IDLE, pc_mux_sel SHALL be 1 for JMP, RET, JV&flag_ex[0], JNV&~flag_ex[0], JZ&flag_ex[1], or JNZ&~flag_ex[1]; otherwise 0.
REQ-023 In IDLE, jmp_loc SHALL be the top-of-stack address for RET and jmp_address_pm for all other opcodes.
REQ-024 FSM states SHALL be IDLE, ENTRY1 and ENTRY2.
REQ-025 An interrupt SHALL be accepted in IDLE only when irq_en=1, |irq=1, depth<DEPTH, and op_dec is not RET.
REQ-026 The accepted source SHALL be the lowest set index.
REQ-027 On acceptance, the FSM SHALL push a return address and the source id at the next clock edge, then enter ENTRY1.
REQ-028 The return address SHALL be the REQ-023 target when pc_mux_sel=1 in that cycle, else current_address+1 (modulo 2^AW).
REQ-029 In ENTRY1: pc_mux_sel=1; jmp_loc=VEC_BASE+id*VEC_STRIDE (AW bits, wrap); irq_ack[id]=1 for this cycle only; op_dec is ignored; next state ENTRY2.
REQ-030 In ENTRY2: flag_ex SHALL be written into the flag slot of the top entry; decode follows REQ-022; next state IDLE.
REQ-031 An interrupt in ENTRY1 or ENTRY2 SHALL stay pending and be evaluated in IDLE.
REQ-032 A RET in IDLE with depth>0 SHALL pop the top entry at the clock edge.
REQ-033 In that same cycle, ret_flags SHALL equal the top-entry flags and ret_flags_vld=1.
REQ-034 A RET with depth=0 SHALL give pc_mux_sel=1, jmp_loc=0, ret_flags_vld=0, and set stack_udf; depth is unchanged.
REQ-035 When depth=DEPTH, interrupts SHALL stay pending without an ack.
REQ-036 depth SHALL be updated only by push and pop, never by both in one cycle.

Reset
REQ-037 While reset=0: state=IDLE, depth=0, all stack entries=0, stack_udf=0, irq_ack=0, ret_flags=0, ret_flags_vld=0.
REQ-038 Reset asserted in ENTRY1 or ENTRY2 SHALL abort entry; no ack follows release.
REQ-039 Outputs SHALL follow REQ-022/023 combinationally from op_dec even during reset.

Verification
REQ-040 With op_dec=011110 and flag_ex=10 -> pc_mux_sel=1, jmp_loc=jmp_address_pm; with flag_ex=00 -> pc_mux_sel=0.
REQ-041 With irq=0100, irq_en=1, current_address=0x0123, non-jump op -> next cycle jmp_loc=0xF020, pc_mux_sel=1, irq_ack=0100; depth=1.
REQ-042 flag_ex=01 during ENTRY2, later RET -> jmp_loc=0x0124, ret_flags=01, ret_flags_vld=1, depth=0.
REQ-043 Accept five interrupts with DEPTH=4 -> the fifth is not acked until a RET pops; then depth=4 again.
REQ-044 RET at depth=0 -> jmp_loc=0, stack_udf=1, held until reset.
REQ-045 irq with JMP taken in the same cycle, target 0x0456 -> stacked return address = 0x0456.

Source files
------------

// File: rtl/int_jump_ctrl.sv
// Branch resolution and vectored interrupt entry with a nested return stack.
// Each stack entry holds the return PC, the interrupt source and the saved flags.
module int_jump_ctrl #(
  parameter int AW = 16,
  parameter int NIRQ = 4,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] VEC_BASE = 16'hF000,
  parameter logic [AW-1:0] VEC_STRIDE = 16'h0010
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [AW-1:0]                jmp_address_pm,
  input  logic [AW-1:0]                current_address,
  input  logic [5:0]                   op_dec,
  input  logic [1:0]                   flag_ex,
  input  logic [NIRQ-1:0]              irq,
  input  logic                         irq_en,
  output logic [AW-1:0]                jmp_loc,
  output logic                         pc_mux_sel,
  output logic [NIRQ-1:0]              irq_ack,
  output logic [1:0]                   ret_flags,
  output logic                         ret_flags_vld,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         stack_udf
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  localparam int XW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [5:0] OP_JV  = 6'b011100;
  localparam logic [5:0] OP_JNV = 6'b011101;
  localparam logic [5:0] OP_JZ  = 6'b011110;
  localparam logic [5:0] OP_JNZ = 6'b011111;
  localparam logic [5:0] OP_JMP = 6'b011000;
  localparam logic [5:0] OP_RET = 6'b010000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY1 = 2'd1,
    ENTRY2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [1:0]    flags;
  } ent_t;

  state_t        state_q;
  ent_t          stk_q [DEPTH];
  logic [DW-1:0] depth_q;
  logic          udf_q;

  logic [XW-1:0] top_idx;
  logic [XW-1:0] push_idx;
  ent_t          top;
  logic          is_ret;
  logic          taken;
  logic          nonempty;
  logic          accept;
  logic [IW-1:0] src;
  logic [AW-1:0] tgt;
  logic [AW-1:0] ret_addr;
  logic [AW-1:0] vec;

  assign top_idx  = XW'(depth_q - DW'(1));
  assign push_idx = XW'(depth_q);
  assign top      = stk_q[top_idx];
  assign nonempty = (depth_q != '0);
  assign is_ret   = (op_dec == OP_RET);

  always_comb begin
    taken = 1'b0;
    unique case (1'b1)
      (op_dec == OP_JMP): taken = 1'b1;
      (op_dec == OP_RET): taken = 1'b1;
      (op_dec == OP_JV):  taken = flag_ex[0];
      (op_dec == OP_JNV): taken = ~flag_ex[0];
      (op_dec == OP_JZ):  taken = flag_ex[1];
      (op_dec == OP_JNZ): taken = ~flag_ex[1];
      default:            taken = 1'b0;
    endcase
  end

  // RET on an empty stack still redirects, to address zero.
  assign tgt = is_ret ? (nonempty ? top.addr : '0) : jmp_address_pm;

  assign ret_addr = taken ? tgt : current_address + AW'(1);

  always_comb begin
    src = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq[i]) src = IW'(i);
    end
  end

  assign accept = (state_q == IDLE) && irq_en && (|irq)
                  && (depth_q < DW'(DEPTH)) && !is_ret;

  assign vec = VEC_BASE + AW'(top.id) * VEC_STRIDE;

  always_comb begin
    jmp_loc       = tgt;
    pc_mux_sel    = taken;
    irq_ack       = '0;
    ret_flags     = '0;
    ret_flags_vld = 1'b0;
    unique case (state_q)
      ENTRY1: begin
        jmp_loc    = vec;
        pc_mux_sel = 1'b1;
        irq_ack    = NIRQ'(1) << top.id;
      end
      IDLE: begin
        if (is_ret && nonempty) begin
          ret_flags     = top.flags;
          ret_flags_vld = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      udf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            stk_q[push_idx] <= '{addr: ret_addr, id: src, flags: 2'b00};
            depth_q         <= depth_q + DW'(1);
            state_q         <= ENTRY1;
          end else if (is_ret) begin
            if (nonempty) depth_q <= depth_q - DW'(1);
            else          udf_q   <= 1'b1;
          end
        end
        ENTRY1: state_q <= ENTRY2;
        ENTRY2: begin
          stk_q[top_idx].flags <= flag_ex;
          state_q              <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign depth     = depth_q;
  assign stack_udf = udf_q;

endmodule

// File: tb/tb_int_jump_ctrl.sv
// Scoreboard bench for int_jump_ctrl: expectations queued at drive time,
// drained and compared at the falling edge of the same cycle.
module tb_int_jump_ctrl;

  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] JV  = 6'b011100;
  localparam logic [5:0] JNV = 6'b011101;
  localparam logic [5:0] JZ  = 6'b011110;
  localparam logic [5:0] JNZ = 6'b011111;
  localparam logic [5:0] JMP = 6'b011000;
  localparam logic [5:0] RET = 6'b010000;

  typedef enum int {S_PC, S_JMP, S_ACK, S_RF, S_RV, S_DEP, S_UDF} sig_t;

  typedef struct {
    string       tag;
    sig_t        sig;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] jmp_address_pm;
  logic [15:0] current_address;
  logic [5:0]  op_dec;
  logic [1:0]  flag_ex;
  logic [3:0]  irq;
  logic        irq_en;
  logic [15:0] jmp_loc;
  logic        pc_mux_sel;
  logic [3:0]  irq_ack;
  logic [1:0]  ret_flags;
  logic        ret_flags_vld;
  logic [2:0]  depth;
  logic        stack_udf;

  int n_chk = 0;
  int n_pass = 0;

  exp_t        sb[$];
  logic [15:0] rs_a[$];
  logic [1:0]  rs_f[$];

  int_jump_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .jmp_address_pm  (jmp_address_pm),
    .current_address (current_address),
    .op_dec          (op_dec),
    .flag_ex         (flag_ex),
    .irq             (irq),
    .irq_en          (irq_en),
    .jmp_loc         (jmp_loc),
    .pc_mux_sel      (pc_mux_sel),
    .irq_ack         (irq_ack),
    .ret_flags       (ret_flags),
    .ret_flags_vld   (ret_flags_vld),
    .depth           (depth),
    .stack_udf       (stack_udf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs(input sig_t s);
    case (s)
      S_PC:    return 32'(pc_mux_sel);
      S_JMP:   return 32'(jmp_loc);
      S_ACK:   return 32'(irq_ack);
      S_RF:    return 32'(ret_flags);
      S_RV:    return 32'(ret_flags_vld);
      S_DEP:   return 32'(depth);
      default: return 32'(stack_udf);
    endcase
  endfunction

  task automatic E(input string tag, input sig_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sig), e.val);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [5:0] op, input logic [1:0] fl,
                     input logic [3:0] iv, input logic en,
                     input logic [15:0] cur, input logic [15:0] ja);
    op_dec          = op;
    flag_ex         = fl;
    irq             = iv;
    irq_en          = en;
    current_address = cur;
    jmp_address_pm  = ja;
  endtask

  task automatic enter(input logic [15:0] cur, input logic [5:0] op,
                       input logic [15:0] ja, input logic [3:0] iv,
                       input int id, input logic [1:0] fl,
                       input logic [15:0] ra, input logic exp_pc);
    drv(op, 2'b00, iv, 1'b1, cur, ja);
    E("acc_pc", S_PC, 32'(exp_pc));
    E("acc_ack", S_ACK, 0);
    E("acc_dep", S_DEP, rs_a.size());
    cyc();
    rs_a.push_back(ra);
    rs_f.push_back(fl);
    drv(NOP, 2'b00, iv, 1'b1, cur, ja);
    E("e1_pc", S_PC, 1);
    E("e1_jmp", S_JMP, 32'h0000F000 + 32'(id) * 32'h10);
    E("e1_ack", S_ACK, 32'(1) << id);
    E("e1_dep", S_DEP, rs_a.size());
    cyc();
    drv(NOP, fl, iv, 1'b1, cur, ja);
    E("e2_ack", S_ACK, 0);
    E("e2_pc", S_PC, 0);
    cyc();
  endtask

  task automatic do_ret(input logic [3:0] iv);
    drv(RET, 2'b00, iv, 1'b1, 16'h0800, 16'h0bad);
    E("ret_pc", S_PC, 1);
    E("ret_jmp", S_JMP, 32'(rs_a[$]));
    E("ret_rf", S_RF, 32'(rs_f[$]));
    E("ret_rv", S_RV, 1);
    E("ret_dep", S_DEP, rs_a.size());
    cyc();
    void'(rs_a.pop_back());
    void'(rs_f.pop_back());
  endtask

  logic [5:0]  t_op [7] = '{JZ, JZ, JNZ, JV, JNV, JMP, NOP};
  logic [1:0]  t_fl [7] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
  logic        t_pc [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b0;
    drv(JMP, 2'b00, 4'b0000, 1'b0, 16'h0010, 16'h0abc);
    E("rst_dep", S_DEP, 0);
    E("rst_udf", S_UDF, 0);
    E("rst_ack", S_ACK, 0);
    E("rst_rv", S_RV, 0);
    E("rst_rf", S_RF, 0);
    E("rst_pc", S_PC, 1);
    E("rst_jmp", S_JMP, 16'h0abc);
    @(negedge clk);
    drain();
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      drv(t_op[i], t_fl[i], 4'b0000, 1'b0, 16'h0100, 16'h1234 + 16'(i));
      E("dec_pc", S_PC, 32'(t_pc[i]));
      if (t_pc[i]) E("dec_jmp", S_JMP, 16'h1234 + 16'(i));
      cyc();
    end

    drv(NOP, 2'b00, 4'b0001, 1'b0, 16'h0100, 16'h0000);
    cyc();
    E("noen_ack", S_ACK, 0);
    E("noen_dep", S_DEP, 0);
    cyc();

    enter(16'h0123, NOP, 16'h0999, 4'b0100, 2, 2'b01, 16'h0124, 1'b0);
    drv(NOP, 2'b00, 4'b0000, 1'b1, 16'h0200, 16'h0000);
    cyc();
    do_ret(4'b0000);
    drv(NOP, 2'b00, 4'b0000, 1'b1, 16'h0200, 16'h0000);
    E("pop_dep", S_DEP, 0);
    E("pop_rv", S_RV, 0);
    cyc();

    enter(16'h0300, JMP, 16'h0456, 4'b1010, 1, 2'b10, 16'h0456, 1'b1);
    drv(NOP, 2'b00, 4'b0000, 1'b1, 16'h0200, 16'h0000);
    cyc();
    do_ret(4'b0000);

    for (int k = 0; k < 4; k++)
      enter(16'h0500 + 16'(k), NOP, 16'h0000, 4'b0001, 0, 2'(k),
            16'h0501 + 16'(k), 1'b0);
    for (int k = 0; k < 2; k++) begin
      drv(NOP, 2'b00, 4'b0001, 1'b1, 16'h0600, 16'h0000);
      E("full_ack", S_ACK, 0);
      E("full_pc", S_PC, 0);
      E("full_dep", S_DEP, 4);
      cyc();
    end
    do_ret(4'b0001);
    enter(16'h0700, NOP, 16'h0000, 4'b0001, 0, 2'b00, 16'h0701, 1'b0);
    drv(NOP, 2'b00, 4'b0000, 1'b1, 16'h0200, 16'h0000);
    E("refill_dep", S_DEP, 4);
    cyc();
    for (int k = 0; k < 4; k++) do_ret(4'b0000);

    drv(RET, 2'b00, 4'b0000, 1'b1, 16'h0200, 16'h0777);
    E("udf_pc", S_PC, 1);
    E("udf_jmp", S_JMP, 0);
    E("udf_rv", S_RV, 0);
    E("udf_dep0", S_DEP, 0);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drv(NOP, 2'b00, 4'b0000, 1'b1, 16'h0200, 16'h0000);
      E("udf_hold", S_UDF, 1);
      E("udf_dep", S_DEP, 0);
      cyc();
    end

    reset = 1'b0;
    E("rst2_udf", S_UDF, 0);
    cyc();
    reset = 1'b1;

    drv(NOP, 2'b00, 4'b0001, 1'b1, 16'h0200, 16'h0000);
    cyc();
    reset = 1'b0;
    E("abort_ack", S_ACK, 0);
    E("abort_dep", S_DEP, 0);
    cyc();
    reset = 1'b1;
    drv(NOP, 2'b00, 4'b0000, 1'b1, 16'h0200, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      E("post_ack", S_ACK, 0);
      E("post_pc", S_PC, 0);
      E("post_dep", S_DEP, 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
